bus_arbiter_rr: RTL and testbench
=================================

// Module: bus_arbiter_rr
// PURPOSE
//  N-master round-robin shared-bus arbiter; successor to the fixed two-core bus. Sits between
//  N core instances and the single gpiomem port. Grants one owner at a time, muxes its
//  address/rw/write-data to memory, and routes read data back to the owner only. Adds
//  hold-timeout preemption, a one-cycle turnaround gap and owner/status outputs.
// PARAMETERS
//  N_MASTERS  2   number of masters (>=2); IDX_W = $clog2(N_MASTERS) localparam
//  ADDR_W     9   address width per master and to memory
//  DATA_W     8   data width
//  MAX_HOLD   16  max consecutive OWNED cycles before preemption when others request; 0 = never
// PORTS
//  clk           in   1                  system clock; sole clock
//  reset         in   1                  synchronous, active-high
//  core_request  in   N_MASTERS          per-master bus request, held for whole transaction
//  core_grant    out  N_MASTERS          one-hot (or zero) grant
//  core_rw       in   N_MASTERS          per-master 1=write, 0=read
//  core_address  in   N_MASTERS*ADDR_W   master i at [i*ADDR_W +: ADDR_W]
//  core_data_in  in   N_MASTERS*DATA_W   write data from master i
//  core_data_out out  N_MASTERS*DATA_W   read data to master i; zero when i not owner
//  RAM_address   out  ADDR_W             to memory
//  RAM_data_in   out  DATA_W             write data to memory
//  RAM_data_out  in   DATA_W             read data from memory
//  rw            out  1                  memory write strobe, 1=write
//  bus_busy      out  1                  1 while state==OWNED
//  owner         out  IDX_W              index of current/last owner
//  preempt       out  1                  one-cycle pulse when a grant is revoked by timeout
// BEHAVIOUR
//  Reset: core_grant=0, core_data_out=0, RAM_address=0, RAM_data_in=0, rw=0, bus_busy=0,
//   owner=0, preempt=0, state=IDLE, rr pointer=N_MASTERS-1 (master 0 wins first), hold_cnt=0.
//   Reset mid-transaction drops grant and write strobe at that edge; no write completes after.
//  States: IDLE, OWNED, TURNAROUND.
//  IDLE: if any core_request, winner = first requester scanning (ptr+1 .. ptr+N) mod N;
//   next edge: core_grant[w]=1, owner=w, ptr=w, hold_cnt=0, -> OWNED. Request->grant = 1 cycle.
//  OWNED: RAM_address/RAM_data_in = owner's fields, rw = core_rw[owner] (combinational from
//   registered owner). core_data_out[owner] = RAM_data_out registered (1-cycle read latency);
//   all other slices 0. hold_cnt increments each cycle, saturates at MAX_HOLD.
//   Exit (next edge, -> TURNAROUND, grant=0) when: core_request[owner]==0, or
//   MAX_HOLD!=0 && hold_cnt==MAX_HOLD-1 && any other request active (preempt=1 that cycle).
//   Release has priority over preemption (no preempt pulse if owner also drops request).
//  TURNAROUND: exactly one cycle; grant=0, rw=0, RAM_address=0, RAM_data_in=0; -> IDLE.
//   Preempted owner is at ptr so has lowest priority on next arbitration.
//  Outside OWNED: rw forced 0, RAM_address/RAM_data_in = 0, core_data_out all 0.
//  Simultaneous new requests: round-robin pointer decides; requests arriving during
//   OWNED/TURNAROUND wait; no request is lost while held. Requests dropped before grant ignored.
//  Sole requester is never preempted (timeout only with a competing request); MAX_HOLD=1
//   preempts after one owned cycle.
//  Invariant: $onehot0(core_grant); rw=1 only in OWNED with core_rw[owner]=1.
// TESTING
//  1 Reset, then core_request=2'b01, write addr 9'h010 data 8'hA5 -> grant[0] next cycle,
//    rw=1, RAM_address=9'h010, RAM_data_in=8'hA5; drop req -> grant 0, TURNAROUND 1 cycle.
//  2 Both request from IDLE after reset -> master 0 wins; on its release master 1 granted
//    exactly 2 cycles after release edge (TURNAROUND+arbitrate); then master 0 again.
//  3 MAX_HOLD=4, master 0 holds, master 1 requests -> after 4 OWNED cycles preempt=1 for
//    one cycle, grant[0]=0, grant[1]=1 two cycles later; owner=1.
//  4 Master 1 read of addr 9'h003 with memory returning 8'h3C -> core_data_out[1]=8'h3C
//    one cycle after address; core_data_out[0] stays 8'h00 throughout.
//  5 N_MASTERS=4, all request continuously, MAX_HOLD=2 -> grant order 0,1,2,3,0; one-hot holds.
//  6 Assert reset mid-write in OWNED -> next edge grant=0, rw=0, owner=0; master 0 wins next.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: N-master round-robin shared-bus arbiter with hold-timeout preemption and turnaround gap
module bus_arbiter_rr #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 8,
  parameter int MAX_HOLD  = 16,
  localparam int IDX_W    = $clog2(N_MASTERS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_MASTERS-1:0]        core_request,
  output logic [N_MASTERS-1:0]        core_grant,
  input  logic [N_MASTERS-1:0]        core_rw,
  input  logic [N_MASTERS*ADDR_W-1:0] core_address,
  input  logic [N_MASTERS*DATA_W-1:0] core_data_in,
  output logic [N_MASTERS*DATA_W-1:0] core_data_out,
  output logic [ADDR_W-1:0]           RAM_address,
  output logic [DATA_W-1:0]           RAM_data_in,
  input  logic [DATA_W-1:0]           RAM_data_out,
  output logic                        rw,
  output logic                        bus_busy,
  output logic [IDX_W-1:0]            owner,
  output logic                        preempt
);
  localparam int HW = $clog2(MAX_HOLD + 2);
  typedef enum logic [1:0] {IDLE, OWNED, TURNAROUND} state_t;
  state_t state, state_nxt;
  logic [IDX_W-1:0] ptr, win;
  logic [HW-1:0] hold_cnt;
  logic owned, release_own, timeout;
  // lowest offset from the pointer wins, so scan from the far end and let nearer requesters overwrite
  always_comb begin
    win = ptr;
    for (int k = N_MASTERS; k >= 1; k--) begin
      if (core_request[(int'(ptr) + k) % N_MASTERS]) win = IDX_W'((int'(ptr) + k) % N_MASTERS);
    end
  end
  assign owned       = state == OWNED;
  assign release_own = !core_request[owner];
  assign timeout     = MAX_HOLD != 0 && hold_cnt == HW'(MAX_HOLD - 1) && |(core_request & ~core_grant);
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= IDX_W'(N_MASTERS - 1);
      owner         <= '0;
      hold_cnt      <= '0;
      core_grant    <= '0;
      core_data_out <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && |core_request) begin
        owner    <= win;
        ptr      <= win;
        hold_cnt <= '0;
      end else if (owned && hold_cnt != HW'(MAX_HOLD)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      core_grant    <= state_nxt == OWNED ? (state == IDLE ? N_MASTERS'(1) << win : core_grant) : '0;
      core_data_out <= owned && state_nxt == OWNED ? (N_MASTERS*DATA_W)'(RAM_data_out) << (owner * DATA_W) : '0;
    end
  end
  always_comb begin
    state_nxt = state == IDLE  ? (|core_request ? OWNED : IDLE) :
                state == OWNED ? (release_own || timeout ? TURNAROUND : OWNED) : IDLE;
  end
  always_comb begin
    RAM_address = owned ? core_address[owner*ADDR_W +: ADDR_W] : '0;
    RAM_data_in = owned ? core_data_in[owner*DATA_W +: DATA_W] : '0;
    rw          = owned && core_rw[owner];
    bus_busy    = owned;
    preempt     = owned && !release_own && timeout;
  end
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: scoreboard bench comparing bus_arbiter_rr against a cycle-level reference model
module tb_bus_arbiter_rr;
  localparam int N = 3, AW = 9, DW = 8, MH = 4, IW = 2;
  logic clk = 0, reset = 1;
  logic [N-1:0] req = '0, rwv = '0, grant;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] din = '0, dout;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_wd, ram_rd;
  logic rw, busy, preempt;
  logic [IW-1:0] owner;
  typedef struct packed {
    logic [N-1:0] g; logic [N*DW-1:0] d; logic [AW-1:0] a; logic [DW-1:0] wd;
    logic w; logic b; logic [IW-1:0] o; logic p;
  } exp_t;
  exp_t q[$];
  int checks = 0, fails = 0;
  int m_st = 0, m_own = 0, m_ptr = N - 1, m_hold = 0;
  logic [N*DW-1:0] m_dout = '0;

  bus_arbiter_rr #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset(reset), .core_request(req), .core_grant(grant), .core_rw(rwv),
    .core_address(addr), .core_data_in(din), .core_data_out(dout), .RAM_address(ram_a),
    .RAM_data_in(ram_wd), .RAM_data_out(ram_rd), .rw(rw), .bus_busy(busy), .owner(owner),
    .preempt(preempt));

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ram_fn(input logic [AW-1:0] a);
    return a[7:0] * 8'd7 + 8'h27;
  endfunction
  assign ram_rd = ram_fn(ram_a);

  function automatic void chk(input string n, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, want, $time);
    end
  endfunction

  // one bus cycle: drive, predict outputs for this cycle, then advance the model at the edge
  task automatic cyc(input logic r, input logic [N-1:0] rq, input logic [N-1:0] w,
                     input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
    exp_t e;
    bit own_c, rel, tmo, found;
    @(negedge clk);
    reset = r; req = rq; rwv = w; addr = a; din = d;
    own_c = m_st == 1;
    rel = !rq[m_own];
    tmo = m_hold == MH - 1 && (rq & ~(N'(1) << m_own)) != '0;
    e.g = own_c ? N'(1) << m_own : '0;
    e.d = m_dout;
    e.a = own_c ? a[m_own*AW +: AW] : '0;
    e.wd = own_c ? d[m_own*DW +: DW] : '0;
    e.w = own_c && w[m_own];
    e.b = own_c;
    e.o = IW'(m_own);
    e.p = own_c && !rel && tmo;
    q.push_back(e);
    @(posedge clk);
    m_dout = '0;
    if (r) begin
      m_st = 0; m_own = 0; m_ptr = N - 1; m_hold = 0;
    end else if (m_st == 0) begin
      if (rq != '0) begin
        found = 0;
        for (int i = 1; i <= N; i++)
          if (!found && rq[(m_ptr + i) % N]) begin found = 1; m_own = (m_ptr + i) % N; end
        m_ptr = m_own; m_hold = 0; m_st = 1;
      end
    end else if (m_st == 1) begin
      if (rel || tmo) m_st = 2;
      else begin
        m_dout[m_own*DW +: DW] = ram_fn(e.a);
        m_hold = m_hold < MH ? m_hold + 1 : MH;
      end
    end else m_st = 0;
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk("grant", 64'(grant), 64'(e.g));
      chk("data_out", 64'(dout), 64'(e.d));
      chk("ram_addr", 64'(ram_a), 64'(e.a));
      chk("ram_wdata", 64'(ram_wd), 64'(e.wd));
      chk("rw", 64'(rw), 64'(e.w));
      chk("bus_busy", 64'(busy), 64'(e.b));
      chk("owner", 64'(owner), 64'(e.o));
      chk("preempt", 64'(preempt), 64'(e.p));
      chk("grant_onehot0", 64'($onehot0(grant)), 64'd1);
    end
  end

  initial begin
    logic [N-1:0] rq_r;
    logic [N*AW-1:0] a_w, a_r;
    logic [N*DW-1:0] d_w;
    a_w = {N{9'h010}}; d_w = {N{8'hA5}}; a_r = {N{9'h003}};
    repeat (2) @(posedge clk);
    // single write by master 0, then release
    repeat (3) cyc(0, 3'b001, 3'b001, a_w, d_w);
    repeat (3) cyc(0, 3'b000, 3'b000, a_w, d_w);
    // simultaneous requests: 0 first, then 1, then 0 again
    repeat (3) cyc(0, 3'b011, 3'b000, a_r, d_w);
    repeat (4) cyc(0, 3'b010, 3'b000, a_r, d_w);
    repeat (4) cyc(0, 3'b001, 3'b000, a_r, d_w);
    repeat (2) cyc(0, 3'b000, 3'b000, a_r, d_w);
    // timeout preemption of a held master
    repeat (12) cyc(0, 3'b011, 3'b001, a_w, d_w);
    repeat (3) cyc(0, 3'b000, 3'b000, a_w, d_w);
    // master 1 read of address 3
    repeat (5) cyc(0, 3'b010, 3'b000, a_r, d_w);
    repeat (2) cyc(0, 3'b000, 3'b000, a_r, d_w);
    // all masters request continuously: rotating grants
    repeat (30) cyc(0, 3'b111, 3'b101, a_w, d_w);
    repeat (3) cyc(0, 3'b000, 3'b000, a_w, d_w);
    // reset in the middle of a write, then master 0 wins again
    repeat (3) cyc(0, 3'b010, 3'b010, a_w, d_w);
    cyc(1, 3'b010, 3'b010, a_w, d_w);
    repeat (4) cyc(0, 3'b011, 3'b011, a_w, d_w);
    rq_r = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        rq_r[i] = rq_r[i] ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) == 0);
      cyc($urandom_range(0, 99) == 0, rq_r, N'($urandom()),
          (N*AW)'({$urandom(), $urandom()}), (N*DW)'($urandom()));
    end
    repeat (2) @(negedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
